vtg_pattern_gen: RTL and testbench

- Video source for scaler benches and on-chip self-test.
- Generates frames on the codebase video stream (do/de/hs/vs) with a programmable size, blanking, pixel cadence and test pattern.
- Output drives scaler_h-style consumers directly.
- It is the transmitter counterpart of the frame monitor.

---
 rtl/vtg_pkg.sv | 20 ++
 rtl/vtg_pattern.sv | 36 +++
 rtl/vtg_pattern_gen.sv | 225 ++++++++++++++++++++++
 tb/tb_vtg_pattern_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vtg_pkg.sv
// rtl/vtg_pkg.sv - shared types and constants for the video timing/pattern generator
package vtg_pkg;

  localparam int VTG_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HBLANK = 2'd2,
    VBLANK = 2'd3
  } vtg_state_e;

  typedef enum logic [1:0] {
    PAT_XRAMP   = 2'd0,
    PAT_DIAG    = 2'd1,
    PAT_NIBBLE  = 2'd2,
    PAT_CHECKER = 2'd3
  } vtg_pat_e;

endpackage

// File: rtl/vtg_pattern.sv
// rtl/vtg_pattern.sv - combinational test-pattern pixel function of (x, y, frame parity, pattern)
module vtg_pattern
  import vtg_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int CNT_WIDTH   = VTG_CNT_WIDTH
) (
  input  logic [CNT_WIDTH-1:0]   x_i,
  input  logic [CNT_WIDTH-1:0]   y_i,
  input  logic                   frame_odd_i,
  input  vtg_pat_e               pattern_i,
  output logic [PIXEL_WIDTH-1:0] pix_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [PIXEL_WIDTH-1:0] w_base;

  // Base pattern value; all arithmetic truncates (or zero-extends) to the pixel width.
  always_comb begin
    w_base = '0;
    case (pattern_i)
      PAT_XRAMP:   w_base = PIXEL_WIDTH'(x_i + CNT_ONE);
      PAT_DIAG:    w_base = PIXEL_WIDTH'(x_i + y_i);
      PAT_NIBBLE:  w_base = PIXEL_WIDTH'({y_i[3:0], x_i[3:0]});
      PAT_CHECKER: w_base = (x_i[3] ^ y_i[3]) ? '1 : '0;
      default:     w_base = '0;
    endcase
  end

  // Odd frames may be inverted so that consecutive frames can be told apart.
  always_comb begin
    pix_o = w_base ^ {PIXEL_WIDTH{frame_odd_i}};
  end

endmodule

// File: rtl/vtg_pattern_gen.sv
// rtl/vtg_pattern_gen.sv - video frame generator (do/de/hs/vs); optional VTG_PATTERN_GEN_FRAME_INV_EN inverts odd frames
module vtg_pattern_gen
  import vtg_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int CNT_WIDTH   = VTG_CNT_WIDTH,
  parameter int DE_PERIOD   = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [CNT_WIDTH-1:0]   cfg_w_i,
  input  logic [CNT_WIDTH-1:0]   cfg_h_i,
  input  logic [CNT_WIDTH-1:0]   cfg_hblank_i,
  input  logic [CNT_WIDTH-1:0]   cfg_vblank_i,
  input  logic [CNT_WIDTH-1:0]   cfg_frames_i,
  input  logic [1:0]             pattern_i,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int                   SLOT     = (DE_PERIOD < 1) ? 1 : DE_PERIOD;
  localparam int                   SUB_W    = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam logic [SUB_W-1:0]     SUB_LAST = SUB_W'(SLOT - 1);
  localparam logic [SUB_W-1:0]     SUB_ONE  = SUB_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH:0]   WIDE_ONE = (CNT_WIDTH + 1)'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  vtg_state_e             r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]   r_x, r_y, r_frame, r_bcnt;
  logic [CNT_WIDTH-1:0]   w_x_nxt, w_y_nxt, w_frame_nxt, w_bcnt_nxt;
  logic [SUB_W-1:0]       r_sub, w_sub_nxt;
  logic                   r_stop, w_stop_nxt;
  logic [CNT_WIDTH-1:0]   r_cfg_w, r_cfg_h, r_cfg_hb, r_cfg_vb, r_cfg_fr;
  logic [CNT_WIDTH-1:0]   w_cfg_w_nxt, w_cfg_h_nxt, w_cfg_hb_nxt, w_cfg_vb_nxt, w_cfg_fr_nxt;
  vtg_pat_e               r_pat, w_pat_nxt;
  logic                   w_done_nxt;
  logic                   w_line_end, w_frame_end, w_hb_end, w_vb_end, w_last_frame;
  logic                   w_frame_odd;
  logic [PIXEL_WIDTH-1:0] w_pix;
  logic [PIXEL_WIDTH-1:0] w_do_nxt;
  logic                   w_de_nxt, w_hs_nxt, w_vs_nxt, w_busy_nxt;

  // Position and blanking-length decodes against the latched configuration.
  always_comb begin
    w_line_end   = (r_x == r_cfg_w - CNT_ONE);
    w_frame_end  = (r_y == r_cfg_h - CNT_ONE);
    w_hb_end     = (({1'b0, r_bcnt} + WIDE_ONE) >= {1'b0, r_cfg_hb});
    w_vb_end     = (({1'b0, r_bcnt} + WIDE_ONE) >= {1'b0, r_cfg_vb});
    w_last_frame = (r_cfg_fr != '0) && (({1'b0, r_frame} + WIDE_ONE) == {1'b0, r_cfg_fr});
  end

  // Next-state and next-counter logic; registered outputs are derived from these next values.
  always_comb begin
    w_state_nxt  = r_state;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_sub_nxt    = r_sub;
    w_frame_nxt  = r_frame;
    w_bcnt_nxt   = r_bcnt;
    w_stop_nxt   = r_stop | stop_i;
    w_cfg_w_nxt  = r_cfg_w;
    w_cfg_h_nxt  = r_cfg_h;
    w_cfg_hb_nxt = r_cfg_hb;
    w_cfg_vb_nxt = r_cfg_vb;
    w_cfg_fr_nxt = r_cfg_fr;
    w_pat_nxt    = r_pat;
    w_done_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        w_stop_nxt = 1'b0;
        if (start_i) begin
          w_cfg_w_nxt  = cfg_w_i;
          w_cfg_h_nxt  = cfg_h_i;
          w_cfg_hb_nxt = cfg_hblank_i;
          w_cfg_vb_nxt = cfg_vblank_i;
          w_cfg_fr_nxt = cfg_frames_i;
          w_pat_nxt    = vtg_pat_e'(pattern_i);
          w_x_nxt      = '0;
          w_y_nxt      = '0;
          w_sub_nxt    = '0;
          w_frame_nxt  = '0;
          w_bcnt_nxt   = '0;
          if ((cfg_w_i == '0) || (cfg_h_i == '0)) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = ACTIVE;
            w_stop_nxt  = stop_i;
          end
        end
      end
      ACTIVE: begin
        if (r_sub == SUB_LAST) begin
          w_sub_nxt = '0;
          if (w_line_end) begin
            w_x_nxt     = '0;
            w_bcnt_nxt  = '0;
            w_state_nxt = w_frame_end ? VBLANK : HBLANK;
          end else begin
            w_x_nxt = r_x + CNT_ONE;
          end
        end else begin
          w_sub_nxt = r_sub + SUB_ONE;
        end
      end
      HBLANK: begin
        if (w_hb_end) begin
          w_bcnt_nxt  = '0;
          w_y_nxt     = r_y + CNT_ONE;
          w_state_nxt = ACTIVE;
        end else begin
          w_bcnt_nxt = r_bcnt + CNT_ONE;
        end
      end
      VBLANK: begin
        if (w_vb_end) begin
          w_bcnt_nxt = '0;
          if (w_last_frame || r_stop || stop_i) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ACTIVE;
            w_y_nxt     = '0;
            w_frame_nxt = (r_frame == CNT_MAX) ? r_frame : r_frame + CNT_ONE;
          end
        end else begin
          w_bcnt_nxt = r_bcnt + CNT_ONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef VTG_PATTERN_GEN_FRAME_INV_EN
  assign w_frame_odd = w_frame_nxt[0];
`else
  assign w_frame_odd = 1'b0;
`endif

  vtg_pattern #(
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_pattern (
    .x_i         (w_x_nxt),
    .y_i         (w_y_nxt),
    .frame_odd_i (w_frame_odd),
    .pattern_i   (w_pat_nxt),
    .pix_o       (w_pix)
  );

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    w_hs_nxt   = (w_state_nxt != ACTIVE);
    w_vs_nxt   = (w_state_nxt == ACTIVE) || (w_state_nxt == HBLANK);
    w_de_nxt   = (w_state_nxt == ACTIVE) && (w_sub_nxt == SUB_LAST);
    w_busy_nxt = (w_state_nxt != IDLE);
    w_do_nxt   = (w_state_nxt == ACTIVE) ? w_pix : '0;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Position counters, sticky stop and configuration latched at run start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x      <= '0;
      r_y      <= '0;
      r_sub    <= '0;
      r_frame  <= '0;
      r_bcnt   <= '0;
      r_stop   <= 1'b0;
      r_cfg_w  <= '0;
      r_cfg_h  <= '0;
      r_cfg_hb <= '0;
      r_cfg_vb <= '0;
      r_cfg_fr <= '0;
      r_pat    <= PAT_XRAMP;
    end else begin
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_sub    <= w_sub_nxt;
      r_frame  <= w_frame_nxt;
      r_bcnt   <= w_bcnt_nxt;
      r_stop   <= w_stop_nxt;
      r_cfg_w  <= w_cfg_w_nxt;
      r_cfg_h  <= w_cfg_h_nxt;
      r_cfg_hb <= w_cfg_hb_nxt;
      r_cfg_vb <= w_cfg_vb_nxt;
      r_cfg_fr <= w_cfg_fr_nxt;
      r_pat    <= w_pat_nxt;
    end
  end

  // Registered video and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      do_o   <= '0;
      de_o   <= 1'b0;
      hs_o   <= 1'b1;
      vs_o   <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      do_o   <= w_do_nxt;
      de_o   <= w_de_nxt;
      hs_o   <= w_hs_nxt;
      vs_o   <= w_vs_nxt;
      busy_o <= w_busy_nxt;
      done_o <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_vtg_pattern_gen.sv
// tb/tb_vtg_pattern_gen.sv - directed self-checking bench for vtg_pattern_gen
module tb_vtg_pattern_gen;

`ifdef VTG_PATTERN_GEN_FRAME_INV_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start0, start4, stop;
  logic [15:0] cfg_w, cfg_h, cfg_hb, cfg_vb, cfg_fr;
  logic [1:0]  pat;

  logic [7:0]  do0, do4;
  logic        de0, hs0, vs0, busy0, done0;
  logic        de4, hs4, vs4, busy4, done4;

  int checks = 0;
  int errors = 0;

  int cyc, de_cnt, lines, frm, y, x, vs_low, gap, bad_de, hv_cnt, act, fcyc, idx;
  int done_cnt;
  logic prev_hs, prev_vs;
  logic [7:0] exp_px;

  vtg_pattern_gen #(.PIXEL_WIDTH(8), .CNT_WIDTH(16), .DE_PERIOD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start0), .stop_i(stop),
    .cfg_w_i(cfg_w), .cfg_h_i(cfg_h), .cfg_hblank_i(cfg_hb), .cfg_vblank_i(cfg_vb),
    .cfg_frames_i(cfg_fr), .pattern_i(pat),
    .do_o(do0), .de_o(de0), .hs_o(hs0), .vs_o(vs0), .busy_o(busy0), .done_o(done0)
  );

  vtg_pattern_gen #(.PIXEL_WIDTH(8), .CNT_WIDTH(16), .DE_PERIOD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_i(start4), .stop_i(stop),
    .cfg_w_i(cfg_w), .cfg_h_i(cfg_h), .cfg_hblank_i(cfg_hb), .cfg_vblank_i(cfg_vb),
    .cfg_frames_i(cfg_fr), .pattern_i(pat),
    .do_o(do4), .de_o(de4), .hs_o(hs4), .vs_o(vs4), .busy_o(busy4), .done_o(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start4 = 1'b0; stop = 1'b0;
    cfg_w = '0; cfg_h = '0; cfg_hb = '0; cfg_vb = '0; cfg_fr = '0; pat = '0;
    repeat (3) step();

    // reset values
    check("rst_do", do0, 0);
    check("rst_de", de0, 0);
    check("rst_hs", hs0, 1);
    check("rst_vs", vs0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_hs4", hs4, 1);
    rst_n = 1'b1;
    step();

    // 24x24 diagonal, 2 frames; cfg inputs scrambled after start must be ignored
    cfg_w = 24; cfg_h = 24; cfg_hb = 10; cfg_vb = 110; cfg_fr = 2; pat = 2'd1;
    start0 = 1'b1; step(); start0 = 1'b0;
    cfg_w = 5; cfg_h = 7; cfg_vb = 3; pat = 2'd0;
    check("t1_first_hs", hs0, 0);
    check("t1_first_vs", vs0, 1);
    check("t1_first_de", de0, 1);
    check("t1_first_do", do0, 0);
    check("t1_first_busy", busy0, 1);
    de_cnt = 0; lines = 0; frm = -1; y = 0; x = 0; vs_low = 0; gap = -1; bad_de = 0;
    done_cnt = 0; prev_hs = 1'b1; prev_vs = 1'b0; cyc = 0;
    while (cyc < 3000) begin
      if (vs0 && !prev_vs) begin
        frm++; y = -1;
        if (frm == 1) gap = vs_low;
      end
      if (prev_hs && !hs0) begin lines++; y++; x = 0; end
      if (!vs0 && busy0) vs_low++;
      if (de0) begin
        de_cnt++;
        if (hs0) bad_de++;
        if (frm == 0 && y == 3) check("t1_line3_px", do0, 3 + x);
        x++;
      end
      prev_hs = hs0; prev_vs = vs0;
      if (done0) begin done_cnt++; break; end
      step(); cyc++;
    end
    check("t1_done_seen", done_cnt, 1);
    check("t1_done_busy", busy0, 0);
    check("t1_done_hs", hs0, 1);
    check("t1_done_vs", vs0, 0);
    check("t1_de_total", de_cnt, 1152);
    check("t1_lines", lines, 48);
    check("t1_vs_gap", gap, 110);
    check("t1_vs_low_total", vs_low, 220);
    check("t1_de_in_blank", bad_de, 0);
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin step(); if (done0) done_cnt++; end
    check("t1_done_single", done_cnt, 0);

    // DE_PERIOD=4 cadence
    cfg_w = 4; cfg_h = 2; cfg_hb = 3; cfg_vb = 2; cfg_fr = 1; pat = 2'd0;
    start4 = 1'b1; step(); start4 = 1'b0;
    for (int c = 0; c < 16; c++) begin
      check("t2_hs", hs4, 0);
      check("t2_de", de4, ((c % 4) == 3) ? 1 : 0);
      check("t2_do", do4, c / 4 + 1);
      step();
    end
    check("t2_hblank_hs", hs4, 1);
    check("t2_hblank_vs", vs4, 1);
    check("t2_hblank_de", de4, 0);
    de_cnt = 0; done_cnt = 0; cyc = 0;
    while (cyc < 200) begin
      if (de4) de_cnt++;
      if (done4) begin done_cnt++; break; end
      step(); cyc++;
    end
    check("t2_line1_de", de_cnt, 4);
    check("t2_done_seen", done_cnt, 1);

    // zero width: stay idle and pulse done at N+1
    cfg_w = 0; cfg_h = 5; cfg_fr = 1;
    start0 = 1'b1; step(); start0 = 1'b0;
    check("t3_w0_done", done0, 1);
    check("t3_w0_busy", busy0, 0);
    check("t3_w0_vs", vs0, 0);
    check("t3_w0_de", de0, 0);
    step();
    check("t3_w0_done_clr", done0, 0);
    act = 0;
    for (int i = 0; i < 5; i++) begin if (vs0 || de0 || busy0) act++; step(); end
    check("t3_w0_quiet", act, 0);

    // hblank=0: one-cycle hs high between lines
    cfg_w = 2; cfg_h = 3; cfg_hb = 0; cfg_vb = 1; cfg_fr = 1; pat = 2'd0;
    start0 = 1'b1; step(); start0 = 1'b0;
    hv_cnt = 0; de_cnt = 0; vs_low = 0; done_cnt = 0; cyc = 0;
    while (cyc < 100) begin
      if (hs0 && vs0) hv_cnt++;
      if (de0) de_cnt++;
      if (!vs0 && busy0) vs_low++;
      if (done0) begin done_cnt++; break; end
      step(); cyc++;
    end
    check("t3_hb0_hblank_cycles", hv_cnt, 2);
    check("t3_hb0_de", de_cnt, 6);
    check("t3_vb0_cycles", vs_low, 1);
    check("t3_hb0_done", done_cnt, 1);

    // continuous mode, stop mid frame 2, start while busy ignored
    cfg_w = 4; cfg_h = 3; cfg_hb = 2; cfg_vb = 3; cfg_fr = 0; pat = 2'd0;
    start0 = 1'b1; step(); start0 = 1'b0;
    de_cnt = 0; lines = 0; frm = 0; fcyc = 0; done_cnt = 0; cyc = 0;
    prev_hs = 1'b1; prev_vs = 1'b0;
    while (cyc < 400) begin
      if (vs0 && !prev_vs) begin frm++; fcyc = 0; end
      if (prev_hs && !hs0) lines++;
      if (de0) de_cnt++;
      prev_hs = hs0; prev_vs = vs0;
      if (done0) begin done_cnt++; break; end
      stop   = (frm == 2 && fcyc == 5);
      start0 = (frm == 2 && fcyc == 5);
      cfg_w  = (frm == 2 && fcyc == 5) ? 16'd8 : 16'd4;
      fcyc++;
      step(); cyc++;
    end
    stop = 1'b0; start0 = 1'b0;
    check("t4_frames", frm, 2);
    check("t4_lines", lines, 6);
    check("t4_de_total", de_cnt, 24);
    check("t4_done", done_cnt, 1);
    act = 0;
    for (int i = 0; i < 5; i++) begin step(); if (busy0 || vs0 || de0) act++; end
    check("t4_idle_after", act, 0);

    // asynchronous reset mid-line
    cfg_w = 24; cfg_h = 4; cfg_hb = 2; cfg_vb = 2; cfg_fr = 1; pat = 2'd0;
    start0 = 1'b1; step(); start0 = 1'b0;
    repeat (5) step();
    check("t5_pre_de", de0, 1);
    check("t5_pre_do", do0, 6);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_do", do0, 0);
    check("t5_rst_de", de0, 0);
    check("t5_rst_hs", hs0, 1);
    check("t5_rst_vs", vs0, 0);
    check("t5_rst_busy", busy0, 0);
    check("t5_rst_done", done0, 0);
    step();
    rst_n = 1'b1;
    act = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (de0 || vs0 || busy0 || done0 || !hs0) act++;
    end
    check("t5_no_activity", act, 0);

    // frame-parity inversion (or identical frames when disabled)
    cfg_w = 4; cfg_h = 1; cfg_hb = 1; cfg_vb = 2; cfg_fr = 2; pat = 2'd0;
    start0 = 1'b1; step(); start0 = 1'b0;
    frm = -1; idx = 0; done_cnt = 0; cyc = 0; prev_vs = 1'b0;
    while (cyc < 100) begin
      if (vs0 && !prev_vs) begin frm++; idx = 0; end
      if (de0) begin
        exp_px = 8'(idx + 1);
        if (INV && frm == 1) exp_px = ~exp_px;
        check("t6_px", do0, exp_px);
        idx++;
      end
      prev_vs = vs0;
      if (done0) begin done_cnt++; break; end
      step(); cyc++;
    end
    check("t6_frames", frm, 1);
    check("t6_done", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
